// File: rtl/main_median9_if.sv
// -----------------------------------------------------------------------------
// main_median9_if
//   Bus between the pixel-window assembler and the median filter.
//   inp : 72-bit window of nine unsigned 8-bit samples, s[k] = inp[8k+7:8k]
//   out : registered 8-bit median of the last completed capture
//   Modports:
//     master - window source (drives inp, observes out)
//     slave  - median filter (observes inp, drives out)
// -----------------------------------------------------------------------------
interface main_median9_if;
  logic [71:0] inp;
  logic [7:0]  out;

  modport master (output inp, input out);
  modport slave  (input inp, output out);
endinterface

// File: rtl/main_median9.sv
// -----------------------------------------------------------------------------
// main_median9
//   Sequential 3x3 median filter. A changed window is captured into a working
//   array, sorted by a 9-phase odd-even transposition network (one phase per
//   clock), and the 5th smallest sample is registered onto the output.
//   Latency: capture at edge N, phases at N+1..N+9, out updates at N+10,
//   earliest next capture at N+11. A constant window is computed once only.
//
//   Ports:
//     clk : system clock, all state updates on the rising edge
//     rst : synchronous, active-high reset (wins over all other activity)
//     bus : main_median9_if.slave (inp = 72-bit window, out = 8-bit median)
//
//   Configuration macro:
//     MAIN_MEDIAN9_RESTART_EN - when defined, a window change seen in SORT or
//     DONE recaptures immediately and the abandoned median is never written.
//     When undefined, such changes wait until IDLE and the in-flight median
//     is always written.
// -----------------------------------------------------------------------------
module main_median9 (
  input  logic           clk,
  input  logic           rst,
  main_median9_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [7:0] sample_t;

  state_t      state_q, state_d;
  sample_t     a_q [9];
  sample_t     a_d [9];
  logic [71:0] last_q, last_d;
  logic [3:0]  phase_q, phase_d;
  logic        first_q, first_d;
  sample_t     out_q, out_d;

  logic        inp_changed;
  assign inp_changed = (bus.inp != last_q);

  // Next-state, sort network and output decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    a_d     = a_q;
    last_d  = last_q;
    phase_d = phase_q;
    first_d = first_q;
    out_d   = out_q;

    unique case (state_q)
      IDLE: begin
        if (first_q || inp_changed) begin
          for (int k = 0; k < 9; k++) a_d[k] = bus.inp[8*k +: 8];
          last_d  = bus.inp;
          first_d = 1'b0;
          phase_d = 4'd0;
          state_d = SORT;
        end
      end

      SORT: begin
`ifdef MAIN_MEDIAN9_RESTART_EN
        if (inp_changed) begin
          for (int k = 0; k < 9; k++) a_d[k] = bus.inp[8*k +: 8];
          last_d  = bus.inp;
          phase_d = 4'd0;
          state_d = SORT;
        end else
`endif
        begin
          // Even phase touches pairs (0,1),(2,3)..; odd phase (1,2),(3,4)..
          // The pairs of one phase are disjoint, so all read the old array.
          // Strict '>' keeps equal values in place.
          for (int i = 0; i < 8; i++) begin
            if ((i[0] == phase_q[0]) && (a_q[i] > a_q[i+1])) begin
              a_d[i]   = a_q[i+1];
              a_d[i+1] = a_q[i];
            end
          end
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd8) state_d = DONE;
        end
      end

      DONE: begin
`ifdef MAIN_MEDIAN9_RESTART_EN
        if (inp_changed) begin
          for (int k = 0; k < 9; k++) a_d[k] = bus.inp[8*k +: 8];
          last_d  = bus.inp;
          phase_d = 4'd0;
          state_d = SORT;
        end else
`endif
        begin
          out_d   = a_q[4];
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the working array is only nine registers and its reset value is
      // part of the defined power-up state, so it is cleared like any flop.
      for (int k = 0; k < 9; k++) a_q[k] <= '0;
      last_q  <= '0;
      phase_q <= '0;
      first_q <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      last_q  <= last_d;
      phase_q <= phase_d;
      first_q <= first_d;
      out_q   <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_main_median9.sv
// -----------------------------------------------------------------------------
// tb_main_median9
//   Directed bench for main_median9. Inputs are driven and outputs sampled
//   1 time unit after each rising edge. Expected medians are hand computed.
//   The window-change-during-sort scenario follows MAIN_MEDIAN9_RESTART_EN.
// -----------------------------------------------------------------------------
module tb_main_median9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  main_median9_if bus ();

  main_median9 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a window from IDLE and check the exact 11-edge latency:
  // out holds prev for 10 edges and shows exp on the 11th.
  task automatic run_vec(input string tag, input logic [71:0] vec,
                         input logic [7:0] prev, input logic [7:0] exp);
    bus.inp = vec;
    repeat (10) tick();
    check({tag, "_hold"}, bus.out, prev);
    tick();
    check(tag, bus.out, exp);
  endtask

  localparam logic [71:0] V1     = 72'hC9E1D5C1B361D4AAF0; // median C9
  localparam logic [71:0] V2     = 72'h4F537FDA836D70FE20; // median 70
  localparam logic [71:0] V3A    = 72'h652DB1E852934DDEED; // median 93
  localparam logic [71:0] V3B    = 72'h4081615F6DE4F7145D; // median 61
  localparam logic [71:0] V_FF   = {9{8'hFF}};             // median FF
  localparam logic [71:0] V_PERM = 72'h030700080205010604; // 0..8 permuted, median 04
  localparam logic [71:0] V_DUP  = 72'h050505010101090909; // median 05

  initial begin
    int done_cnt;

    // Test 1: reset, then first capture of held window.
    bus.inp = V1;
    rst = 1'b1;
    tick();
    check("reset_out", bus.out, 8'h00);
    tick();                        // release edge
    check("reset_out2", bus.out, 8'h00);
    rst = 1'b0;
    run_vec("t1_first", V1, 8'h00, 8'hC9);

    // Test 2: constant window over 50 cycles computes exactly once.
    bus.inp = V2;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (dut.state_q == 2'd2) done_cnt++;
    end
    check("t2_median", bus.out, 8'h70);
    check("t2_done_count", done_cnt, 1);

    // Test 3: two back-to-back windows.
    run_vec("t3_a", V3A, 8'h70, 8'h93);
    run_vec("t3_b", V3B, 8'h93, 8'h61);

    // Test 4: all equal, permutation of 0..8, positional duplicates.
    run_vec("t4_ff",   V_FF,   8'h61, 8'hFF);
    run_vec("t4_perm", V_PERM, 8'hFF, 8'h04);
    run_vec("t4_dup",  V_DUP,  8'h04, 8'h05);

    // Test 5: change the window while phase 4 is pending.
    bus.inp = V1;
    tick();                        // capture edge N
    repeat (4) tick();             // phases 0..3 done, phase 4 next
    bus.inp = V2;
`ifdef MAIN_MEDIAN9_RESTART_EN
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t5_skip_old", bus.out, 8'h05);
    end
    tick();
    check("t5_new", bus.out, 8'h70);
`else
    repeat (5) tick();
    check("t5_old_hold", bus.out, 8'h05);
    tick();                        // DONE edge writes the in-flight median
    check("t5_old", bus.out, 8'hC9);
    repeat (10) tick();
    check("t5_new_hold", bus.out, 8'hC9);
    tick();
    check("t5_new", bus.out, 8'h70);
`endif

    // Test 6: reset during SORT aborts and the held window is recomputed.
    bus.inp = V3A;
    tick();                        // capture
    repeat (3) tick();             // mid-sort
    rst = 1'b1;
    tick();
    check("t6_reset_out", bus.out, 8'h00);
    rst = 1'b0;
    run_vec("t6_recompute", V3A, 8'h00, 8'h93);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
